// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline hazard unit:
//               scoreboard entry layout, forwarding-select encoding and the
//               mode enumeration used by the controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Widest register address the scoreboard entry can carry. Narrower
    // address widths are zero-extended into the rd field.
    localparam int unsigned c_RD_MAXW = 8;

    // Forwarding select value meaning "take the operand from the register file".
    // Any non-zero select k means "take the result held in tracked stage k".
    localparam int unsigned FWD_RF = 0;

    // One tracked in-flight instruction.
    typedef struct packed {
        logic                 v;   // slot holds a real instruction
        logic [c_RD_MAXW-1:0] rd;  // destination register
        logic                 wr;  // instruction writes rd
        logic                 ld;  // result comes from a load
    } sb_entry_t;

    // An empty slot; used wherever a bubble enters the pipeline.
    localparam sb_entry_t c_SB_BUBBLE = '0;

    // Controller modes, listed highest priority first.
    typedef enum logic [2:0] {
        FREEZE   = 3'd0,
        REDIRECT = 3'd1,
        BUSY     = 3'd2,
        HAZARD   = 3'd3,
        RUN      = 3'd4
    } mode_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/hz_match.sv
`default_nettype none
// ============================================================================
// Module      : hz_match
// Description : Per-source operand search over the in-flight scoreboard.
//               Finds the youngest tracked stage that will write the source
//               register, and decides whether its result can be forwarded
//               now or whether the consumer must wait.
// Revision    : 1.0 - initial release
// ============================================================================
module hz_match
    import pipe_pkg::*;
#(
    parameter int NSTAGE  = 3,
    parameter int REG_AW  = 5,
    parameter int ALU_STG = 1,
    parameter int LD_STG  = 3,
    parameter int FWD_EN  = 1
) (
    input  logic [REG_AW-1:0]              src_i,
    input  logic                           used_i,
    input  sb_entry_t [NSTAGE:1]           sb_i,
    output logic [$clog2(NSTAGE+1)-1:0]    sel_o,
    output logic                           hazard_o
);

    localparam int SELW     = $clog2(NSTAGE + 1);
    localparam bit c_FWD_ON = (FWD_EN != 0);

    logic            w_found;
    logic            w_avail;
    logic [SELW-1:0] w_k;

    // Scan from the oldest stage towards stage 1 so the youngest match is
    // the one left standing; x0 and unread sources never match.
    always_comb begin
        w_found = 1'b0;
        w_avail = 1'b0;
        w_k     = SELW'(FWD_RF);
        for (int k = NSTAGE; k >= 1; k--) begin
            if (used_i && (src_i != '0) && sb_i[k].v && sb_i[k].wr &&
                (sb_i[k].rd == c_RD_MAXW'(src_i))) begin
                w_found = 1'b1;
                w_k     = SELW'(k);
                // Load data appears later in the pipe than ALU results.
                w_avail = sb_i[k].ld ? (k >= LD_STG) : (k >= ALU_STG);
            end
        end
    end

    // A match that cannot be forwarded right now is a data hazard; while it
    // holds, the select stays on the register file.
    assign hazard_o = w_found && !(w_avail && c_FWD_ON);
    assign sel_o    = (w_found && w_avail && c_FWD_ON) ? w_k : SELW'(FWD_RF);

endmodule : hz_match
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Hazard, forwarding and stall controller for the in-order
//               pipeline. Shadows the destination registers of every stage
//               after ID, produces operand forwarding selects and drives the
//               write-enable / flush inputs of the pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int NSTAGE  = 3,
    parameter int REG_AW  = 5,
    parameter int ALU_STG = 1,
    parameter int LD_STG  = 3,
    parameter int FWD_EN  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid_i,
    input  logic [REG_AW-1:0]           id_rs1_i,
    input  logic [REG_AW-1:0]           id_rs2_i,
    input  logic                        id_rs1_used_i,
    input  logic                        id_rs2_used_i,
    input  logic [REG_AW-1:0]           id_rd_i,
    input  logic                        id_regwrite_i,
    input  logic                        id_memread_i,
    input  logic                        ex_redirect_i,
    input  logic                        ex_busy_i,
    input  logic                        mem_ready_i,
    output logic [$clog2(NSTAGE+1)-1:0] fwd_sel1_o,
    output logic [$clog2(NSTAGE+1)-1:0] fwd_sel2_o,
    output logic                        pc_we_o,
    output logic                        ifid_we_o,
    output logic                        ifid_flush_o,
    output logic                        idex_flush_o,
    output logic                        front_we_o,
    output logic                        back_we_o,
    output logic                        exmem_flush_o,
    output logic [31:0]                 stall_cnt_o
);

    // Scoreboard: entry 1 mirrors ID/EX, entry NSTAGE mirrors MEM/WB.
    sb_entry_t [NSTAGE:1] sb_q;
    sb_entry_t [NSTAGE:1] sb_d;

    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    logic        w_haz1;
    logic        w_haz2;
    logic        w_data_hazard;
    mode_e       w_mode;
    sb_entry_t   w_id_entry;

    // ------------------------------------------------------------------
    // Operand searches, one per ID source
    // ------------------------------------------------------------------
    hz_match #(
        .NSTAGE  (NSTAGE),
        .REG_AW  (REG_AW),
        .ALU_STG (ALU_STG),
        .LD_STG  (LD_STG),
        .FWD_EN  (FWD_EN)
    ) u_match_rs1 (
        .src_i    (id_rs1_i),
        .used_i   (id_rs1_used_i),
        .sb_i     (sb_q),
        .sel_o    (fwd_sel1_o),
        .hazard_o (w_haz1)
    );

    hz_match #(
        .NSTAGE  (NSTAGE),
        .REG_AW  (REG_AW),
        .ALU_STG (ALU_STG),
        .LD_STG  (LD_STG),
        .FWD_EN  (FWD_EN)
    ) u_match_rs2 (
        .src_i    (id_rs2_i),
        .used_i   (id_rs2_used_i),
        .sb_i     (sb_q),
        .sel_o    (fwd_sel2_o),
        .hazard_o (w_haz2)
    );

    assign w_data_hazard = w_haz1 | w_haz2;

    // What the ID instruction looks like once it moves into stage 1.
    assign w_id_entry = '{
        v:  id_valid_i,
        rd: c_RD_MAXW'(id_rd_i),
        wr: id_regwrite_i,
        ld: id_memread_i
    };

    // ------------------------------------------------------------------
    // Mode selection
    // ------------------------------------------------------------------
    // Pick the single active mode, highest priority first. A redirect
    // raised while stage 1 is busy or memory is stalled simply waits: stage
    // 1 holds, so the branch keeps requesting it.
    always_comb begin
        w_mode = RUN;
        if (!mem_ready_i) begin
            w_mode = FREEZE;
        end else if (ex_redirect_i && !ex_busy_i) begin
            w_mode = REDIRECT;
        end else if (ex_busy_i) begin
            w_mode = BUSY;
        end else if (id_valid_i && w_data_hazard) begin
            w_mode = HAZARD;
        end
    end

    // Translate the mode into pipeline-register enables and flushes.
    always_comb begin
        pc_we_o       = 1'b1;
        ifid_we_o     = 1'b1;
        front_we_o    = 1'b1;
        back_we_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        case (w_mode)
            FREEZE: begin
                pc_we_o    = 1'b0;
                ifid_we_o  = 1'b0;
                front_we_o = 1'b0;
                back_we_o  = 1'b0;
            end
            REDIRECT: begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end
            BUSY: begin
                // Stage 1 and everything in front of it hold; the back end
                // drains and sees bubbles behind the multi-cycle op.
                pc_we_o       = 1'b0;
                ifid_we_o     = 1'b0;
                front_we_o    = 1'b0;
                exmem_flush_o = 1'b1;
            end
            HAZARD: begin
                pc_we_o      = 1'b0;
                ifid_we_o    = 1'b0;
                idex_flush_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard and stall counter next state
    // ------------------------------------------------------------------
    // Move the scoreboard exactly as the real pipeline registers will move.
    always_comb begin
        sb_d = sb_q;
        case (w_mode)
            FREEZE: begin
            end
            BUSY: begin
                for (int k = 2; k <= NSTAGE; k++) begin
                    sb_d[k] = (k == 2) ? c_SB_BUBBLE : sb_q[k-1];
                end
            end
            REDIRECT, HAZARD: begin
                sb_d[1] = c_SB_BUBBLE;
                for (int k = 2; k <= NSTAGE; k++) begin
                    sb_d[k] = sb_q[k-1];
                end
            end
            default: begin
                sb_d[1] = w_id_entry;
                for (int k = 2; k <= NSTAGE; k++) begin
                    sb_d[k] = sb_q[k-1];
                end
            end
        endcase
    end

    // Count every cycle the PC is held, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers; reset discards every in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule : pipe_hazard_unit
`default_nettype wire

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard, forwarding and stall controller for the in-order RISC-V pipeline. It replaces the stall-only hazard logic at the CPU top level. The block keeps a shadow scoreboard of in-flight destination registers for every stage after ID and produces:
- forwarding selects;
- load-use and multi-cycle stalls;
- memory-wait freezes and branch flushes.

It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their write-enable and flush inputs.

## Interface
Parameters:
- NSTAGE, 3, number of tracked stages after ID (1 = ID/EX, …, NSTAGE = MEM/WB).
- REG_AW, 5, register address width.
- ALU_STG, 1, first stage whose non-load result is forwardable.
- LD_STG, 3, first stage whose load result is forwardable.
- FWD_EN, 1, 0 = legacy mode: any pending match stalls, no forwarding.

Ports. Reset is asynchronous, active-low. One clock.
- clk, in, 1, pipeline clock.
- rst_n, in, 1, asynchronous active-low reset.
- id_valid, in, 1, IF/ID holds a real instruction.
- id_rs1, in, REG_AW, ID source 1.
- id_rs2, in, REG_AW, ID source 2.
- id_rs1_used, in, 1, instruction reads rs1.
- id_rs2_used, in, 1, instruction reads rs2.
- id_rd, in, REG_AW, ID destination.
- id_regwrite, in, 1, ID writes rd.
- id_memread, in, 1, ID instruction is a load.
- ex_redirect, in, 1, taken branch/jump resolved in stage 1.
- ex_busy, in, 1, multi-cycle op occupying stage 1.
- mem_ready, in, 1, data memory ready (MIO_ready).
- fwd_sel1, out, $clog2(NSTAGE+1), rs1 source: 0 = RF, k = stage k result.
- fwd_sel2, out, $clog2(NSTAGE+1), rs2 source, same encoding.
- pc_we, out, 1, PC write enable.
- ifid_we, out, 1, IF/ID write enable.
- ifid_flush, out, 1, IF/ID clear.
- idex_flush, out, 1, inject bubble into ID/EX.
- front_we, out, 1, ID/EX write enable.
- back_we, out, 1, EX/MEM and MEM/WB write enable.
- exmem_flush, out, 1, inject bubble into EX/MEM.
- stall_cnt, out, 32, saturating count of cycles with pc_we = 0.

## Operation
- Scoreboard entry k (1..NSTAGE) holds {v, rd, wr, ld}.
- Entry k matches source r when v & wr & rd == r & r != 0 & the corresponding *_used input is set. x0 never matches.
- An entry is available when:
  - ld = 0 and k ≥ ALU_STG; or
  - ld = 1 and k ≥ LD_STG.
- For each source, find the youngest (lowest k) matching entry:
  - none → sel = 0;
  - available and FWD_EN = 1 → sel = k;
  - otherwise → data hazard. The source's sel is 0 while the hazard holds.
- Modes are evaluated in priority order. pc_we, ifid_we and front_we are 1, and all flushes are 0, unless a mode below says otherwise.
  1. FREEZE (mem_ready = 0): all write enables 0, no flushes, scoreboard holds.
  2. REDIRECT (ex_redirect & !ex_busy): ifid_flush = 1, idex_flush = 1, all enables 1. Entry 1 becomes a bubble.
  3. BUSY (ex_busy): pc_we = ifid_we = front_we = 0, back_we = 1, exmem_flush = 1. Entry 1 holds; entry 2 gets a bubble; entries ≥ 3 shift.
  4. HAZARD (id_valid & data hazard): pc_we = ifid_we = 0, idex_flush = 1, others 1. Bubble into entry 1, older entries shift.
  5. RUN: all enables 1. Entry 1 ← {id_valid, id_rd, id_regwrite, id_memread}; entries shift.
- ex_redirect asserted during FREEZE or BUSY is acted on in the first cycle neither applies. Stage 1 holds, so redirect stays asserted.
- stall_cnt increments on every cycle with pc_we = 0 and saturates at 0xFFFF_FFFF.

## Timing
- Forwarding selects and all control outputs are combinational from the scoreboard and ID inputs, settling within the same cycle.
- The scoreboard updates on the rising clk edge.
- Reset values:
  - all entries v = 0;
  - stall_cnt = 0;
  - hence fwd_sel = 0, no stall, no flush; all enables 1 while mem_ready = 1.
- rst_n deassertion mid-stream discards all in-flight entries. The first post-reset instruction sees no hazard.
- Load-use at distance 1 with defaults: exactly 2 stall cycles, then fwd = 3.
- ALU dependence at distance 1: fwd = 1, no stall.
- FWD_EN = 0: a dependence stalls until no matching entry remains, i.e. the producer has written back. This is legacy-equivalent.

## Structure
- Shared package `pipe_pkg` holds:
  - the scoreboard entry struct;
  - the fwd_sel encoding constants (FWD_RF = 0);
  - the mode enum {FREEZE, REDIRECT, BUSY, HAZARD, RUN}.
- One sub-module, `hz_match`: per-source youngest-match / availability search, instantiated twice.

## Test plan
- ALU chain: add x5 then sub x6,x5,x1 back-to-back → fwd_sel1 = 1, pc_we stays 1, stall_cnt = 0.
- Load-use: lw x7 then add x8,x7,x7 → pc_we = 0 for 2 cycles, idex_flush = 1 both cycles, then fwd_sel1 = fwd_sel2 = 3, stall_cnt = 2.
- Redirect during BUSY: ex_busy = 1 for 4 cycles with ex_redirect = 1 → flushes only in cycle 5. Entry 2 carries bubbles during cycles 1-4.
- mem_ready = 0 for 3 cycles mid-hazard → every enable 0, scoreboard unchanged, stall_cnt += 3, and the hazard resumes afterward.
- x0 destination and FWD_EN = 0:
  - write x0 then read x0 → no stall, fwd_sel = 0;
  - with FWD_EN = 0, an ALU dependence at distance 1 → 3 stall cycles.
- Async reset asserted with 3 valid entries → on release, fwd_sel = 0, no stall, stall_cnt = 0.
